fir_tap_line: RTL

Parametrised streaming tap line that feeds the FIR/wavelet filter bank. It synchronises an external sample strobe and shifts samples into a NUM_TAPS-deep tap register. It tracks fill level and decimates the calculation trigger. It also flags overrun when a trigger coincides with a busy filter bank. It sits between the sample input pins and the parallel FIR engines.

---
 rtl/fir_tap_line_if.sv | 35 +++
 rtl/fir_tap_line.sv | 94 +++++++++
 2 files changed

// File: rtl/fir_tap_line_if.sv
// fir_tap_line_if: sample, control and tap-vector bundle
// between the sample front end and the FIR tap line.
interface fir_tap_line_if #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_TAPS      = 9,
  parameter int DECIM_W       = 4,
  parameter int FILL_W        = 4
) ();
  localparam int TOTAL_BITS = NUM_TAPS * BITS_PER_ELEM;

  logic [BITS_PER_ELEM-1:0] i_value;
  logic                     i_data_clk;
  logic [DECIM_W-1:0]       i_decim;
  logic                     i_clear;
  logic                     i_busy;
  logic [TOTAL_BITS-1:0]    o_taps;
  logic                     o_start_calc;
  logic                     o_primed;
  logic [FILL_W-1:0]        o_fill;
  logic                     o_overrun;

  modport master (
    output i_value, i_data_clk, i_decim,
    output i_clear, i_busy,
    input  o_taps, o_start_calc, o_primed,
    input  o_fill, o_overrun
  );

  modport slave (
    input  i_value, i_data_clk, i_decim,
    input  i_clear, i_busy,
    output o_taps, o_start_calc, o_primed,
    output o_fill, o_overrun
  );
endinterface

// File: rtl/fir_tap_line.sv
// fir_tap_line: synchronised strobe, tap shift register,
// fill tracking, decimated trigger and overrun flag.
module fir_tap_line #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_TAPS      = 9,
  parameter int DECIM_W       = 4,
  parameter int FILL_W        = 4
) (
  input logic          clk,
  input logic          rst,
  fir_tap_line_if.slave bus
);
  localparam int TOTAL_BITS = NUM_TAPS * BITS_PER_ELEM;
  localparam int KEEP_BITS  = TOTAL_BITS - BITS_PER_ELEM;
  localparam logic [FILL_W-1:0] FULL = FILL_W'(NUM_TAPS);

  logic [2:0]            sync_q, sync_d;
  logic [TOTAL_BITS-1:0] taps_q, taps_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [DECIM_W-1:0]    dc_q, dc_d;
  logic                  start_q, start_d;
  logic                  ovr_q, ovr_d;

  logic                  accept;
  logic                  hit;
  logic                  trig;
  logic [DECIM_W-1:0]    r_m1;
  logic [FILL_W-1:0]     fill_inc;

  // Edge detect, decimation hit and trigger qualification
  always_comb begin
    sync_d   = {sync_q[1:0], bus.i_data_clk};
    accept   = sync_q[1] & ~sync_q[2] & ~bus.i_clear;
    r_m1     = (bus.i_decim == '0) ? '0
             : bus.i_decim - DECIM_W'(1);
    hit      = (dc_q >= r_m1);
    fill_inc = (fill_q == FULL) ? fill_q
             : fill_q + FILL_W'(1);
    trig     = accept & hit & (fill_inc == FULL);
  end

  // Next state for taps, fill, decimation and flags
  always_comb begin
    taps_d  = taps_q;
    fill_d  = fill_q;
    dc_d    = dc_q;
    ovr_d   = ovr_q;
    start_d = 1'b0;
    if (bus.i_clear) begin
      taps_d = '0;
      fill_d = '0;
      dc_d   = '0;
      ovr_d  = 1'b0;
    end else if (accept) begin
      taps_d = {taps_q[KEEP_BITS-1:0], bus.i_value};
      fill_d = fill_inc;
      dc_d   = hit ? '0 : dc_q + DECIM_W'(1);
      if (trig) begin
        if (bus.i_busy) ovr_d   = 1'b1;
        else            start_d = 1'b1;
      end
    end
  end

  // Synchroniser is deliberately untouched by clear so a
  // strobe still high afterwards cannot re-trigger
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  // Datapath and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_q  <= '0;
      fill_q  <= '0;
      dc_q    <= '0;
      start_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      taps_q  <= taps_d;
      fill_q  <= fill_d;
      dc_q    <= dc_d;
      start_q <= start_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.o_taps       = taps_q;
  assign bus.o_fill       = fill_q;
  assign bus.o_start_calc = start_q;
  assign bus.o_overrun    = ovr_q;
  assign bus.o_primed     = (fill_q == FULL);
endmodule
